// File: rtl/ysyx_22050499_pkg.sv
// Shared definitions for the LSU: FSM state codes, access size codes,
// the AXI OKAY response code and the alignment check.
package ysyx_22050499_pkg;

    typedef logic [2:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE  = 3'd0;
    localparam lsu_state_t ST_ERR   = 3'd1;
    localparam lsu_state_t ST_RADDR = 3'd2;
    localparam lsu_state_t ST_RDATA = 3'd3;
    localparam lsu_state_t ST_WREQ  = 3'd4;
    localparam lsu_state_t ST_WRESP = 3'd5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // A request is rejected when its size code is illegal or its address
    // is not naturally aligned for that size.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_22050499_lsu_ext.sv
// Load data extraction: the responder already lane-shifts the addressed
// byte to bit 0, so this only selects the width and extends it.
import ysyx_22050499_pkg::*;

module ysyx_22050499_lsu_ext (
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    // Width select plus sign or zero extension.
    always_comb begin
        data = 32'd0;
        case (size)
            SZ_BYTE: begin
                if (sign_ext) begin
                    data = {{24{rdata[7]}}, rdata[7:0]};
                end else begin
                    data = {24'd0, rdata[7:0]};
                end
            end
            SZ_HALF: begin
                if (sign_ext) begin
                    data = {{16{rdata[15]}}, rdata[15:0]};
                end else begin
                    data = {16'd0, rdata[15:0]};
                end
            end
            SZ_WORD: data = rdata;
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/ysyx_22050499_lsu_axi.sv
// Load/store unit bridging a simple core request port onto AXI4-Lite.
// One transaction at a time; all bus and response outputs are registered.
import ysyx_22050499_pkg::*;

module ysyx_22050499_lsu_axi #(
    parameter int TIMEOUT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    // Counter value on which the timeout fires (unused when TIMEOUT is 0).
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    lsu_state_t  state_r;
    logic [1:0]  size_r;
    logic        signed_r;
    logic [31:0] tmo_cnt_r;
    logic        arvalid_r, rready_r, awvalid_r, wvalid_r, bready_r;
    logic [31:0] araddr_r, awaddr_r, wdata_r;
    logic [3:0]  wstrb_r;
    logic        resp_valid_r, resp_err_r;
    logic [31:0] resp_rdata_r;

    logic        accept_s;
    logic        req_ready_s;
    logic        in_bus_s;
    logic        tmo_hit_s;
    logic        aw_done_s;
    logic        w_done_s;
    logic [31:0] st_wdata_s;
    logic [3:0]  st_wstrb_s;
    logic [31:0] ext_data_s;

    ysyx_22050499_lsu_ext u_ext (
        .rdata    (rdata),
        .size     (size_r),
        .sign_ext (signed_r),
        .data     (ext_data_s)
    );

    // Acceptance is blocked while a response pulse is on the wire.
    always_comb begin
        req_ready_s = (state_r == ST_IDLE) && !resp_valid_r;
        accept_s    = req_valid && req_ready_s;
        in_bus_s    = (state_r == ST_RADDR) || (state_r == ST_RDATA) ||
                      (state_r == ST_WREQ)  || (state_r == ST_WRESP);
        aw_done_s   = !awvalid_r || awready;
        w_done_s    = !wvalid_r || wready;
    end

    // Timeout fires on the last allowed bus-wait cycle.
    always_comb begin
        if ((TIMEOUT != 0) && in_bus_s && (tmo_cnt_r == TMO_LAST)) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Store lane placement and byte strobes from the incoming request.
    always_comb begin
        st_wdata_s = req_wdata << {req_addr[1:0], 3'b000};
        case (req_size)
            SZ_BYTE: st_wstrb_s = 4'b0001;
            SZ_HALF: st_wstrb_s = 4'b0011;
            SZ_WORD: st_wstrb_s = 4'b1111;
            default: st_wstrb_s = 4'b0000;
        endcase
        st_wstrb_s = st_wstrb_s << req_addr[1:0];
    end

    // Transaction FSM with registered bus handshakes and response pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            size_r       <= SZ_BYTE;
            signed_r     <= 1'b0;
            tmo_cnt_r    <= 32'd0;
            arvalid_r    <= 1'b0;
            araddr_r     <= 32'd0;
            rready_r     <= 1'b0;
            awvalid_r    <= 1'b0;
            awaddr_r     <= 32'd0;
            wvalid_r     <= 1'b0;
            wdata_r      <= 32'd0;
            wstrb_r      <= 4'b0000;
            bready_r     <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
        end else begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
            if (in_bus_s) begin
                tmo_cnt_r <= tmo_cnt_r + 32'd1;
            end else begin
                tmo_cnt_r <= 32'd0;
            end

            if (tmo_hit_s) begin
                state_r      <= ST_IDLE;
                tmo_cnt_r    <= 32'd0;
                arvalid_r    <= 1'b0;
                rready_r     <= 1'b0;
                awvalid_r    <= 1'b0;
                wvalid_r     <= 1'b0;
                bready_r     <= 1'b0;
                resp_valid_r <= 1'b1;
                resp_err_r   <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (accept_s) begin
                            size_r   <= req_size;
                            signed_r <= req_signed;
                            if (req_bad(req_size, req_addr[1:0])) begin
                                state_r <= ST_ERR;
                            end else if (!req_wen) begin
                                state_r   <= ST_RADDR;
                                araddr_r  <= req_addr;
                                arvalid_r <= 1'b1;
                            end else begin
                                state_r   <= ST_WREQ;
                                awaddr_r  <= req_addr;
                                wdata_r   <= st_wdata_s;
                                wstrb_r   <= st_wstrb_s;
                                awvalid_r <= 1'b1;
                                wvalid_r  <= 1'b1;
                            end
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_ERR: begin
                        state_r      <= ST_IDLE;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b1;
                    end
                    ST_RADDR: begin
                        if (arready) begin
                            arvalid_r <= 1'b0;
                            rready_r  <= 1'b1;
                            state_r   <= ST_RDATA;
                        end else begin
                            state_r <= ST_RADDR;
                        end
                    end
                    ST_RDATA: begin
                        if (rvalid) begin
                            rready_r     <= 1'b0;
                            state_r      <= ST_IDLE;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= (rresp != RESP_OKAY);
                            if (rresp == RESP_OKAY) begin
                                resp_rdata_r <= ext_data_s;
                            end else begin
                                resp_rdata_r <= 32'd0;
                            end
                        end else begin
                            state_r <= ST_RDATA;
                        end
                    end
                    ST_WREQ: begin
                        if (awready) begin
                            awvalid_r <= 1'b0;
                        end else begin
                            awvalid_r <= awvalid_r;
                        end
                        if (wready) begin
                            wvalid_r <= 1'b0;
                        end else begin
                            wvalid_r <= wvalid_r;
                        end
                        if (aw_done_s && w_done_s) begin
                            state_r  <= ST_WRESP;
                            bready_r <= 1'b1;
                        end else begin
                            state_r <= ST_WREQ;
                        end
                    end
                    ST_WRESP: begin
                        if (bvalid) begin
                            bready_r     <= 1'b0;
                            state_r      <= ST_IDLE;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= (bresp != RESP_OKAY);
                        end else begin
                            state_r <= ST_WRESP;
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b0;
                        awvalid_r <= 1'b0;
                        wvalid_r  <= 1'b0;
                        bready_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        req_ready  = req_ready_s;
        resp_valid = resp_valid_r;
        resp_err   = resp_err_r;
        resp_rdata = resp_rdata_r;
        araddr     = araddr_r;
        arvalid    = arvalid_r;
        rready     = rready_r;
        awaddr     = awaddr_r;
        awvalid    = awvalid_r;
        wdata      = wdata_r;
        wstrb      = wstrb_r;
        wvalid     = wvalid_r;
        bready     = bready_r;
    end

endmodule

// File: tb/tb_ysyx_22050499_lsu_axi.sv
// Table-driven bench for the LSU with a scoreboard queue of expected
// responses and a cycle-stepped AXI responder with programmable delays.
module tb_ysyx_22050499_lsu_axi;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wen, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    ysyx_22050499_lsu_axi #(.TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_signed(req_signed), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata),
        .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bresp(bresp),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] bus_rdata;
        logic [1:0]  bus_resp;
        int          ar_lat, aw_lat, w_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        int          exp_ar, exp_aw, exp_w, exp_b;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } sb_t;

    sb_t  sbq[$];
    vec_t vt[17];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [1:0] size, input logic sgn, input logic [31:0] brd,
                                input logic [1:0] brsp, input int arl, input int awl, input int wl,
                                input logic [31:0] erd, input logic eerr, input int elat,
                                input logic [31:0] ewd, input logic [3:0] ews,
                                input int ear, input int eaw, input int ew, input int eb);
        vec_t v;
        v.wen = wen; v.addr = addr; v.wd = wd; v.size = size; v.sgn = sgn;
        v.bus_rdata = brd; v.bus_resp = brsp; v.ar_lat = arl; v.aw_lat = awl; v.w_lat = wl;
        v.exp_rdata = erd; v.exp_err = eerr; v.exp_lat = elat; v.exp_wdata = ewd; v.exp_wstrb = ews;
        v.exp_ar = ear; v.exp_aw = eaw; v.exp_w = ew; v.exp_b = eb;
        return v;
    endfunction

    task automatic bus_idle();
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    endtask

    // Issue one request, act as AXI responder cycle by cycle, check the response.
    task automatic run(input vec_t v, input string nm);
        int k, ar_c, aw_c, w_c, ar_hs, aw_hs, w_hs, b_hs, arv_seen, awv_seen;
        bit done;
        sb_t e;
        ar_c = 0; aw_c = 0; w_c = 0; ar_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        arv_seen = 0; awv_seen = 0; done = 1'b0;
        @(negedge clock);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wd;
        req_size = v.size; req_signed = v.sgn;
        sbq.push_back('{v.exp_rdata, v.exp_err, v.exp_lat});
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        for (k = 1; k <= 40 && !done; k++) begin
            arready = arvalid && (ar_c >= v.ar_lat);
            if (arvalid) begin
                arv_seen++;
                if (arready) begin
                    ar_hs++;
                    chk({nm, "_araddr"}, araddr, v.addr);
                end
                ar_c++;
            end
            rvalid = rready; rdata = v.bus_rdata; rresp = v.bus_resp;
            awready = awvalid && (aw_c >= v.aw_lat);
            if (awvalid) begin
                awv_seen++;
                if (awready) begin
                    aw_hs++;
                    chk({nm, "_awaddr"}, awaddr, v.addr);
                end
                aw_c++;
            end
            wready = wvalid && (w_c >= v.w_lat);
            if (wvalid) begin
                if (wready) begin
                    w_hs++;
                    chk({nm, "_wdata"}, wdata, v.exp_wdata);
                    chk({nm, "_wstrb"}, {28'd0, wstrb}, {28'd0, v.exp_wstrb});
                end
                w_c++;
            end
            bvalid = bready; bresp = v.bus_resp;
            if (bready) b_hs++;
            if (resp_valid) begin
                done = 1'b1;
                if (sbq.size() == 0) begin
                    chk({nm, "_sb_empty"}, 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk({nm, "_rdata"}, resp_rdata, e.rdata);
                    chk({nm, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
                    chk({nm, "_lat"}, k, e.lat);
                end
                chk({nm, "_busy_in_resp"}, {31'd0, req_ready}, 32'd0);
                chk({nm, "_quiet"}, {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
            end
            @(negedge clock);
        end
        bus_idle();
        if (!done) chk({nm, "_no_resp"}, 32'd0, 32'd1);
        chk({nm, "_ready_after"}, {31'd0, req_ready}, 32'd1);
        chk({nm, "_ar_hs"}, ar_hs, v.exp_ar);
        chk({nm, "_aw_hs"}, aw_hs, v.exp_aw);
        chk({nm, "_w_hs"}, w_hs, v.exp_w);
        chk({nm, "_b_hs"}, b_hs, v.exp_b);
        if (v.exp_lat == 2) begin
            chk({nm, "_no_arvalid"}, arv_seen, 0);
            chk({nm, "_no_awvalid"}, awv_seen, 0);
        end
    endtask

    initial begin
        //          wen  addr          wdata         sz     sg   bus_rdata     rsp   arl awl wl  exp_rdata     err  lat exp_wdata     strb     ar aw w  b
        vt[0]  = mk(1'b0, 32'h80000004, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 2'b00, 0, 0, 0, 32'hDEADBEEF, 1'b0, 3, 32'h0,        4'b0000, 1, 0, 0, 0);
        vt[1]  = mk(1'b0, 32'h80000003, 32'h0,        2'b00, 1'b1, 32'h00000080, 2'b00, 0, 0, 0, 32'hFFFFFF80, 1'b0, 3, 32'h0,        4'b0000, 1, 0, 0, 0);
        vt[2]  = mk(1'b0, 32'h80000003, 32'h0,        2'b00, 1'b0, 32'h00000080, 2'b00, 0, 0, 0, 32'h00000080, 1'b0, 3, 32'h0,        4'b0000, 1, 0, 0, 0);
        vt[3]  = mk(1'b0, 32'h80000002, 32'h0,        2'b01, 1'b1, 32'h12348001, 2'b00, 0, 0, 0, 32'hFFFF8001, 1'b0, 3, 32'h0,        4'b0000, 1, 0, 0, 0);
        vt[4]  = mk(1'b0, 32'h80000002, 32'h0,        2'b01, 1'b0, 32'hFFFF7FFF, 2'b00, 0, 0, 0, 32'h00007FFF, 1'b0, 3, 32'h0,        4'b0000, 1, 0, 0, 0);
        vt[5]  = mk(1'b0, 32'h80000010, 32'h0,        2'b10, 1'b1, 32'h80000000, 2'b00, 2, 0, 0, 32'h80000000, 1'b0, 5, 32'h0,        4'b0000, 1, 0, 0, 0);
        vt[6]  = mk(1'b0, 32'h80000014, 32'h0,        2'b10, 1'b0, 32'h12345678, 2'b10, 0, 0, 0, 32'h00000000, 1'b1, 3, 32'h0,        4'b0000, 1, 0, 0, 0);
        vt[7]  = mk(1'b0, 32'h80000001, 32'h0,        2'b10, 1'b0, 32'h0,        2'b00, 0, 0, 0, 32'h00000000, 1'b1, 2, 32'h0,        4'b0000, 0, 0, 0, 0);
        vt[8]  = mk(1'b0, 32'h80000003, 32'h0,        2'b01, 1'b0, 32'h0,        2'b00, 0, 0, 0, 32'h00000000, 1'b1, 2, 32'h0,        4'b0000, 0, 0, 0, 0);
        vt[9]  = mk(1'b0, 32'h80000000, 32'h0,        2'b11, 1'b0, 32'h0,        2'b00, 0, 0, 0, 32'h00000000, 1'b1, 2, 32'h0,        4'b0000, 0, 0, 0, 0);
        vt[10] = mk(1'b1, 32'h80000002, 32'h0000ABCD, 2'b01, 1'b0, 32'h0,        2'b00, 0, 2, 0, 32'h00000000, 1'b0, 5, 32'hABCD0000, 4'b1100, 0, 1, 1, 1);
        vt[11] = mk(1'b1, 32'h80000001, 32'h0000005A, 2'b00, 1'b0, 32'h0,        2'b00, 0, 0, 0, 32'h00000000, 1'b0, 3, 32'h00005A00, 4'b0010, 0, 1, 1, 1);
        vt[12] = mk(1'b1, 32'h80000008, 32'h11223344, 2'b10, 1'b0, 32'h0,        2'b00, 0, 0, 1, 32'h00000000, 1'b0, 4, 32'h11223344, 4'b1111, 0, 1, 1, 1);
        vt[13] = mk(1'b1, 32'h8000000C, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0,        2'b10, 0, 0, 0, 32'h00000000, 1'b1, 3, 32'hCAFEF00D, 4'b1111, 0, 1, 1, 1);
        vt[14] = mk(1'b1, 32'h80000001, 32'h00001234, 2'b01, 1'b0, 32'h0,        2'b00, 0, 0, 0, 32'h00000000, 1'b1, 2, 32'h0,        4'b0000, 0, 0, 0, 0);
        vt[15] = mk(1'b0, 32'h80000020, 32'h0,        2'b10, 1'b0, 32'h0,        2'b00, 1000, 0, 0, 32'h00000000, 1'b1, 9, 32'h0,     4'b0000, 0, 0, 0, 0);
        vt[16] = mk(1'b0, 32'h80000000, 32'h0,        2'b00, 1'b1, 32'hFFFFFF7F, 2'b00, 0, 0, 0, 32'h0000007F, 1'b0, 3, 32'h0,        4'b0000, 1, 0, 0, 0);

        reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_size = 2'b00; req_signed = 1'b0;
        bus_idle();
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_outputs", {25'd0, arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 17; i++) begin
            run(vt[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a load, while waiting in the data phase.
        @(negedge clock);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h80000030; req_size = 2'b10; req_signed = 1'b0;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        chk("mid_arvalid", {31'd0, arvalid}, 32'd1);
        arready = 1'b1;
        @(negedge clock);
        arready = 1'b0;
        chk("mid_rready", {31'd0, rready}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_quiet", {26'd0, arvalid, rready, awvalid, wvalid, bready, resp_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_post_quiet", {26'd0, arvalid, rready, resp_valid, resp_err, wvalid, bready}, 32'd0);
        run(vt[0], "after_rst");

        chk("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
